// File: rtl/inst_buffer_pkg.sv
// Shared fetch-side definitions: instruction-buffer entry layout and defaults.
package inst_buffer_pkg;

    localparam int unsigned PC_W     = 32;
    localparam int unsigned INST_W   = 32;
    localparam int unsigned ECAUSE_W = 7;

    // Entry bit offsets, LSB first: pred_addr, taken, cause, is_exc, inst, pc.
    localparam int unsigned OFF_PRED  = 0;
    localparam int unsigned OFF_TAKEN = OFF_PRED + PC_W;
    localparam int unsigned OFF_CAUSE = OFF_TAKEN + 1;
    localparam int unsigned OFF_EXC   = OFF_CAUSE + ECAUSE_W;
    localparam int unsigned OFF_INST  = OFF_EXC + 1;
    localparam int unsigned OFF_PC    = OFF_INST + INST_W;
    localparam int unsigned ENTRY_W   = OFF_PC + PC_W;

    // Free-entry threshold covering two in-flight cache-stage fetch pairs.
    localparam int unsigned STALL_FREE_DEF = 4;

    typedef struct packed {
        logic [PC_W-1:0]     pc;
        logic [INST_W-1:0]   inst;
        logic                is_exc;
        logic [ECAUSE_W-1:0] cause;
        logic                taken;
        logic [PC_W-1:0]     pred_addr;
    } entry_t;

endpackage

// File: rtl/inst_buffer.sv
// Instruction buffer: decoupling FIFO between I-cache and decode.
// Accepts up to two entries per cycle, presents the two oldest, and
// raises a registered fetch stall when free space runs low.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned PTR_W      = 4,
    parameter int unsigned STALL_FREE = STALL_FREE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [PC_W-1:0]     in_pc1,
    input  logic [PC_W-1:0]     in_pc2,
    input  logic [INST_W-1:0]   in_inst1,
    input  logic [INST_W-1:0]   in_inst2,
    input  logic [PC_W-1:0]     in_pred_addr,
    input  logic [1:0]          in_pred_taken,
    input  logic                in_is_exception1,
    input  logic                in_is_exception2,
    input  logic [ECAUSE_W-1:0] in_exception_cause1,
    input  logic [ECAUSE_W-1:0] in_exception_cause2,
    output logic                fetch_stall,
    output logic                out_valid1,
    output logic                out_valid2,
    output logic [PC_W-1:0]     out_pc1,
    output logic [PC_W-1:0]     out_pc2,
    output logic [INST_W-1:0]   out_inst1,
    output logic [INST_W-1:0]   out_inst2,
    output logic                out_pred_taken1,
    output logic                out_pred_taken2,
    output logic [PC_W-1:0]     out_pred_addr1,
    output logic [PC_W-1:0]     out_pred_addr2,
    output logic                out_is_exception1,
    output logic                out_is_exception2,
    output logic [ECAUSE_W-1:0] out_exception_cause1,
    output logic [ECAUSE_W-1:0] out_exception_cause2,
    input  logic                dec_pop1,
    input  logic                dec_pop2,
    output logic                overflow_err
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0]   head1, tail1;
    logic [PTR_W:0]     count_q, count_d;
    logic [PTR_W:0]     free_now, free_next;
    logic [1:0]         push_req, push_n, pop_req, pop_n;
    logic               push_ok;
    logic               fetch_stall_q, fetch_stall_d;
    logic               overflow_q, overflow_d;
    entry_t             wr1, wr2;
    logic [ENTRY_W-1:0] rd1, rd2;

    // Push/pop arbitration, pointer/count next state and stall threshold.
    always_comb begin
        push_req = '0;
        if (in_valid && !flush) begin
            // A taken slot1 or faulting slot1 ends the fetch group at one entry.
            push_req = (in_pred_taken[0] || in_is_exception1) ? 2'd1 : 2'd2;
        end
        // Space is judged on the current count only; same-cycle pops are not credited.
        free_now   = (PTR_W+1)'(DEPTH) - count_q;
        push_ok    = free_now >= {{(PTR_W-1){1'b0}}, push_req};
        push_n     = push_ok ? push_req : 2'd0;
        overflow_d = overflow_q | ~push_ok;

        pop_req = {1'b0, dec_pop1} + {1'b0, dec_pop1 & dec_pop2};
        // Over-popping is clamped; count is below 2 whenever this clamp applies.
        pop_n   = ({{(PTR_W-1){1'b0}}, pop_req} > count_q) ? count_q[1:0] : pop_req;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(pop_n);
            tail_d  = tail_q + PTR_W'(push_n);
            count_d = count_q + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
        end
        free_next     = (PTR_W+1)'(DEPTH) - count_d;
        fetch_stall_d = !flush && (free_next <= (PTR_W+1)'(STALL_FREE));

        head1 = head_q + PTR_W'(1);
        tail1 = tail_q + PTR_W'(1);

        wr1 = '{pc: in_pc1, inst: in_inst1, is_exc: in_is_exception1,
                cause: in_exception_cause1, taken: in_pred_taken[0],
                pred_addr: in_pred_addr};
        wr2 = '{pc: in_pc2, inst: in_inst2, is_exc: in_is_exception2,
                cause: in_exception_cause2, taken: in_pred_taken[1],
                pred_addr: in_pred_addr};
    end

    // Pointer, count and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            fetch_stall_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            fetch_stall_q <= fetch_stall_d;
            overflow_q    <= overflow_d;
        end
    end

    // Entry array: slot1 at tail, slot2 at tail+1 (wraps to index 0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[PTR_W'(i)] <= '0;
            end
        end else begin
            if (push_n != 2'd0) mem_q[tail_q] <= wr1;
            if (push_n == 2'd2) mem_q[tail1]  <= wr2;
        end
    end

    assign rd1 = mem_q[head_q];
    assign rd2 = mem_q[head1];

    assign out_valid1           = (count_q != '0);
    assign out_valid2           = (count_q > (PTR_W+1)'(1));
    assign out_pc1              = rd1[OFF_PC +: PC_W];
    assign out_pc2              = rd2[OFF_PC +: PC_W];
    assign out_inst1            = rd1[OFF_INST +: INST_W];
    assign out_inst2            = rd2[OFF_INST +: INST_W];
    assign out_pred_taken1      = rd1[OFF_TAKEN];
    assign out_pred_taken2      = rd2[OFF_TAKEN];
    assign out_pred_addr1       = rd1[OFF_PRED +: PC_W];
    assign out_pred_addr2       = rd2[OFF_PRED +: PC_W];
    assign out_is_exception1    = rd1[OFF_EXC];
    assign out_is_exception2    = rd2[OFF_EXC];
    assign out_exception_cause1 = rd1[OFF_CAUSE +: ECAUSE_W];
    assign out_exception_cause2 = rd2[OFF_CAUSE +: ECAUSE_W];
    assign fetch_stall          = fetch_stall_q;
    assign overflow_err         = overflow_q;

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer with a queue-based reference of buffer contents.
module tb_inst_buffer;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid;
    logic [31:0] in_pc1, in_pc2, in_inst1, in_inst2, in_pred_addr;
    logic [1:0]  in_pred_taken;
    logic        in_is_exception1, in_is_exception2;
    logic [6:0]  in_exception_cause1, in_exception_cause2;
    logic        fetch_stall, out_valid1, out_valid2;
    logic [31:0] out_pc1, out_pc2, out_inst1, out_inst2;
    logic        out_pred_taken1, out_pred_taken2;
    logic [31:0] out_pred_addr1, out_pred_addr2;
    logic        out_is_exception1, out_is_exception2;
    logic [6:0]  out_exception_cause1, out_exception_cause2;
    logic        dec_pop1, dec_pop2, overflow_err;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] paddr;
        logic        exc;
        logic        taken;
        logic [6:0]  cause;
    } ent_t;

    ent_t sb[$];
    logic stall_m, ovf_m;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    inst_buffer #(.DEPTH(16), .PTR_W(4), .STALL_FREE(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_pc1(in_pc1), .in_pc2(in_pc2), .in_inst1(in_inst1), .in_inst2(in_inst2),
        .in_pred_addr(in_pred_addr), .in_pred_taken(in_pred_taken),
        .in_is_exception1(in_is_exception1), .in_is_exception2(in_is_exception2),
        .in_exception_cause1(in_exception_cause1), .in_exception_cause2(in_exception_cause2),
        .fetch_stall(fetch_stall), .out_valid1(out_valid1), .out_valid2(out_valid2),
        .out_pc1(out_pc1), .out_pc2(out_pc2), .out_inst1(out_inst1), .out_inst2(out_inst2),
        .out_pred_taken1(out_pred_taken1), .out_pred_taken2(out_pred_taken2),
        .out_pred_addr1(out_pred_addr1), .out_pred_addr2(out_pred_addr2),
        .out_is_exception1(out_is_exception1), .out_is_exception2(out_is_exception2),
        .out_exception_cause1(out_exception_cause1), .out_exception_cause2(out_exception_cause2),
        .dec_pop1(dec_pop1), .dec_pop2(dec_pop2), .overflow_err(overflow_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid1"}, out_valid1, sb.size() >= 1);
        chk({tag, ".valid2"}, out_valid2, sb.size() >= 2);
        chk({tag, ".count"}, dut.count_q, sb.size());
        chk({tag, ".stall"}, fetch_stall, stall_m);
        chk({tag, ".ovf"}, overflow_err, ovf_m);
        if (sb.size() >= 1) begin
            chk({tag, ".pc1"}, out_pc1, sb[0].pc);
            chk({tag, ".inst1"}, out_inst1, sb[0].inst);
            chk({tag, ".paddr1"}, out_pred_addr1, sb[0].paddr);
            chk({tag, ".taken1"}, out_pred_taken1, sb[0].taken);
            chk({tag, ".exc1"}, out_is_exception1, sb[0].exc);
            chk({tag, ".cause1"}, out_exception_cause1, sb[0].cause);
        end
        if (sb.size() >= 2) begin
            chk({tag, ".pc2"}, out_pc2, sb[1].pc);
            chk({tag, ".inst2"}, out_inst2, sb[1].inst);
            chk({tag, ".paddr2"}, out_pred_addr2, sb[1].paddr);
            chk({tag, ".taken2"}, out_pred_taken2, sb[1].taken);
            chk({tag, ".exc2"}, out_is_exception2, sb[1].exc);
            chk({tag, ".cause2"}, out_exception_cause2, sb[1].cause);
        end
    endtask

    // Reference update at an active edge, using the inputs held across it.
    task automatic model_edge();
        int   pr, pop, sz;
        ent_t e1, e2;
        if (flush) begin
            sb.delete();
            stall_m = 1'b0;
        end else begin
            pr  = !in_valid ? 0 : ((in_pred_taken[0] || in_is_exception1) ? 1 : 2);
            sz  = sb.size();
            pop = dec_pop1 ? (dec_pop2 ? 2 : 1) : 0;
            if (pop > sz) pop = sz;
            e1 = '{pc: in_pc1, inst: in_inst1, paddr: in_pred_addr,
                   exc: in_is_exception1, taken: in_pred_taken[0], cause: in_exception_cause1};
            e2 = '{pc: in_pc2, inst: in_inst2, paddr: in_pred_addr,
                   exc: in_is_exception2, taken: in_pred_taken[1], cause: in_exception_cause2};
            for (int k = 0; k < pop; k++) void'(sb.pop_front());
            if ((16 - sz) < pr) begin
                ovf_m = 1'b1;
            end else begin
                if (pr >= 1) sb.push_back(e1);
                if (pr == 2) sb.push_back(e2);
            end
            stall_m = ((16 - sb.size()) <= 4);
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [31:0] pc,
                        input logic [1:0] tk, input logic e1, input logic e2,
                        input logic p1, input logic p2, input logic fl);
        in_valid            = v;
        in_pc1              = pc;
        in_pc2              = pc + 32'd4;
        in_inst1            = ~pc;
        in_inst2            = {pc[15:0], pc[31:16]} ^ 32'h1357_9BDF;
        in_pred_addr        = pc + 32'h100;
        in_pred_taken       = tk;
        in_is_exception1    = e1;
        in_is_exception2    = e2;
        in_exception_cause1 = pc[6:0] ^ 7'h2A;
        in_exception_cause2 = pc[8:2];
        dec_pop1            = p1;
        dec_pop2            = p2;
        flush               = fl;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; flush = 1'b0; dec_pop1 = 1'b0; dec_pop2 = 1'b0;
        in_pred_taken = 2'b00; in_is_exception1 = 1'b0; in_is_exception2 = 1'b0;
    endtask

    task automatic model_reset();
        sb.delete();
        stall_m = 1'b0;
        ovf_m   = 1'b0;
    endtask

    initial begin
        logic [31:0] pc;
        in_pc1 = '0; in_pc2 = '0; in_inst1 = '0; in_inst2 = '0; in_pred_addr = '0;
        in_exception_cause1 = '0; in_exception_cause2 = '0;
        idle_inputs();
        rst = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        chk("reset.pc1_zero", out_pc1, 32'h0);
        rst = 1'b1;

        // Basic pair, then a taken slot1 that truncates the pair while draining the first.
        step("pair", 1, 32'h1C00_0000, 2'b00, 0, 0, 0, 0, 0);
        chk("pair.pc1_lit", out_pc1, 32'h1C00_0000);
        step("taken", 1, 32'h1C00_0000, 2'b01, 0, 0, 1, 1, 0);
        chk("taken.paddr_lit", out_pred_addr1, 32'h1C00_0100);
        chk("taken.valid2_lit", out_valid2, 1'b0);
        step("pop1", 0, 32'h0, 2'b00, 0, 0, 1, 0, 0);

        // Fill with 8 pairs, then a 9th pair that must be dropped.
        pc = 32'h1C00_1000;
        for (int i = 0; i < 8; i++) begin
            step("fill", 1, pc, 2'b00, 0, 0, 0, 0, 0);
            pc += 32'd8;
        end
        step("drop", 1, pc, 2'b00, 0, 0, 0, 0, 0);
        chk("drop.ovf_lit", overflow_err, 1'b1);
        for (int i = 0; i < 8; i++) step("drain", 0, 32'h0, 2'b00, 0, 0, 1, 1, 0);

        // Exception and slot2-taken variants; pop2-only and clamped over-pop.
        step("exc1", 1, 32'h1C00_2000, 2'b00, 1, 1, 0, 0, 0);
        step("exc2", 1, 32'h1C00_2010, 2'b10, 0, 1, 0, 0, 0);
        step("pop2only", 0, 32'h0, 2'b00, 0, 0, 0, 1, 0);
        step("popa", 0, 32'h0, 2'b00, 0, 0, 1, 1, 0);
        step("clamp", 0, 32'h0, 2'b00, 0, 0, 1, 1, 0);

        // Wrap: flush to index 0, set tail to 15, then push a pair with a pop.
        step("flush0", 0, 32'h0, 2'b00, 0, 0, 0, 0, 1);
        pc = 32'h2000_0000;
        for (int i = 0; i < 7; i++) begin
            step("wfill", 1, pc, 2'b00, 0, 0, 0, 0, 0);
            pc += 32'd8;
        end
        step("wpop", 0, 32'h0, 2'b00, 0, 0, 1, 1, 0);
        step("wpop", 0, 32'h0, 2'b00, 0, 0, 1, 1, 0);
        step("wsingle", 1, pc, 2'b01, 0, 0, 0, 0, 0);
        step("wrap", 1, 32'h2000_0100, 2'b00, 0, 0, 1, 0, 0);
        chk("wrap.tail_lit", dut.tail_q, 32'd1);
        for (int i = 0; i < 6; i++) step("wdrain", 0, 32'h0, 2'b00, 0, 0, 1, 1, 0);

        // Flush has priority over a simultaneous push and double pop.
        step("f5a", 1, 32'h3000_0000, 2'b00, 0, 0, 0, 0, 0);
        step("f5b", 1, 32'h3000_0008, 2'b00, 0, 0, 0, 0, 0);
        step("f5c", 1, 32'h3000_0010, 2'b01, 0, 0, 0, 0, 0);
        step("flush", 1, 32'h3000_0020, 2'b00, 0, 0, 1, 1, 1);
        chk("flush.valid1_lit", out_valid1, 1'b0);

        // Asynchronous reset in the middle of a cycle with seven entries held.
        step("r7a", 1, 32'h4000_0000, 2'b00, 0, 0, 0, 0, 0);
        step("r7b", 1, 32'h4000_0008, 2'b00, 0, 0, 0, 0, 0);
        step("r7c", 1, 32'h4000_0010, 2'b00, 0, 0, 0, 0, 0);
        step("r7d", 1, 32'h4000_0018, 2'b01, 0, 0, 0, 0, 0);
        idle_inputs();
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        chk("arst.inst1_zero", out_inst1, 32'h0);
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rst");
        chk("post_rst.inst1_zero", out_inst1, 32'h0);
        step("post_push", 1, 32'h5000_0000, 2'b00, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
